exc_ctrl: RTL and testbench

//  Exception/interrupt controller for the MEM stage. Merges the per-instruction exception flags with
//  the CP0 interrupt state and drives the CP0 exception-commit inputs (excepttype, PC, delay-slot flag, bad address).

---
 rtl/exc_ctrl.sv | 176 +++++++++++++++++
 tb/tb_exc_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt controller: selects one exception code, drives CP0 commit, flush and redirect PC.
// Latency: commit outputs are combinational in the commit cycle; REFILL_CYCLES idle cycles follow each commit.
// Backpressure: stall_i holds off any commit; while busy_o is high all inputs are ignored.
// Build option: define EXC_INT_SYNC_EN to pass int_i through a 2-flop synchroniser (+2 cycles interrupt latency).
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
    parameter int unsigned REFILL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        inst_valid_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic [8:0]  exc_flags_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_ds_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic        busy_o
);

    typedef enum logic [0:0] {ST_IDLE, ST_REFILL} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(REFILL_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  int_s;

`ifdef EXC_INT_SYNC_EN
    logic [5:0]  int_s1_q, int_s1_d;
    logic [5:0]  int_s2_q, int_s2_d;

    // two-stage shift of the raw interrupt lines
    always_comb begin
        int_s1_d = int_i;
        int_s2_d = int_s1_q;
    end

    // synchroniser flops, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            int_s1_q <= '0;
            int_s2_q <= '0;
        end else begin
            int_s1_q <= int_s1_d;
            int_s2_q <= int_s2_d;
        end
    end

    assign int_s = int_s2_q;
`else
    assign int_s = int_i;
`endif

    // CP0 values as they will be after this cycle's MTC0, so a same-cycle write takes effect
    logic [31:0] eff_status;
    logic [31:0] eff_epc;
    logic [1:0]  eff_cause_ip;
    logic [7:0]  ip;
    logic        int_take;

    assign eff_status   = (cp0_we_i && cp0_waddr_i == 5'd12) ? cp0_wdata_i : status_i;
    assign eff_epc      = (cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : epc_i;
    assign eff_cause_ip = (cp0_we_i && cp0_waddr_i == 5'd13) ? cp0_wdata_i[9:8] : cause_i[9:8];
    assign ip           = {int_s, eff_cause_ip} & eff_status[15:8];
    assign int_take     = (ip != 8'd0) && eff_status[0] && !eff_status[1];

    // only these CP0 bits matter here; the rest are folded away
    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};

    logic [31:0] code;
    logic [31:0] bad_addr;
    logic        is_eret;

    // priority encoder: interrupt first, then the flags in pipeline-age order, ERET last
    always_comb begin
        code     = 32'd0;
        bad_addr = 32'd0;
        is_eret  = 1'b0;
        if (int_take) begin
            code = 32'h01;
        end else if (exc_flags_i[0]) begin
            code     = 32'h04;
            bad_addr = pc_i;
        end else if (exc_flags_i[1]) begin
            code = 32'h0a;
        end else if (exc_flags_i[2]) begin
            code = 32'h08;
        end else if (exc_flags_i[3]) begin
            code = 32'h09;
        end else if (exc_flags_i[4]) begin
            code = 32'h0c;
        end else if (exc_flags_i[5]) begin
            code = 32'h0d;
        end else if (exc_flags_i[6]) begin
            code     = 32'h04;
            bad_addr = mem_addr_i;
        end else if (exc_flags_i[7]) begin
            code     = 32'h05;
            bad_addr = mem_addr_i;
        end else if (exc_flags_i[8]) begin
            code    = 32'h0e;
            is_eret = 1'b1;
        end
    end

    // FSM next state and outputs; outputs are all zero unless committing, and forced zero under reset
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        excepttype_o = 32'd0;
        exc_pc_o     = 32'd0;
        exc_ds_o     = 1'b0;
        bad_addr_o   = 32'd0;
        flush_o      = 1'b0;
        newpc_o      = 32'd0;
        busy_o       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inst_valid_i && !stall_i && code != 32'd0) begin
                    excepttype_o = code;
                    exc_pc_o     = pc_i;
                    exc_ds_o     = in_delayslot_i;
                    bad_addr_o   = bad_addr;
                    flush_o      = 1'b1;
                    newpc_o      = is_eret ? eff_epc : EXC_VECTOR;
                    state_d      = ST_REFILL;
                    cnt_d        = CNT_LOAD;
                end
            end
            ST_REFILL: begin
                busy_o = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            excepttype_o = 32'd0;
            exc_pc_o     = 32'd0;
            exc_ds_o     = 1'b0;
            bad_addr_o   = 32'd0;
            flush_o      = 1'b0;
            newpc_o      = 32'd0;
            busy_o       = 1'b0;
        end
    end

    // state and refill counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam int F_ADELF = 0, F_RI = 1, F_SYS = 2, F_BRK = 3, F_OV = 4,
                   F_TRAP = 5, F_ADELD = 6, F_ADES = 7, F_ERET = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, inst_valid_i, in_delayslot_i, cp0_we_i;
    logic [31:0] pc_i, mem_addr_i, status_i, cause_i, epc_i, cp0_wdata_i;
    logic [8:0]  exc_flags_i;
    logic [5:0]  int_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] excepttype_o, exc_pc_o, bad_addr_o, newpc_o;
    logic        exc_ds_o, flush_o, busy_o;
    logic [31:0] et1, epc1, bad1, npc1;
    logic        ds1, flush1, busy1;

    always #5 clk = ~clk;

    exc_ctrl #(.EXC_VECTOR(VEC), .REFILL_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .inst_valid_i(inst_valid_i),
        .pc_i(pc_i), .in_delayslot_i(in_delayslot_i), .mem_addr_i(mem_addr_i),
        .exc_flags_i(exc_flags_i), .int_i(int_i), .status_i(status_i),
        .cause_i(cause_i), .epc_i(epc_i), .cp0_we_i(cp0_we_i),
        .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
        .excepttype_o(excepttype_o), .exc_pc_o(exc_pc_o), .exc_ds_o(exc_ds_o),
        .bad_addr_o(bad_addr_o), .flush_o(flush_o), .newpc_o(newpc_o), .busy_o(busy_o)
    );

    // second instance: single-cycle refill boundary
    exc_ctrl #(.EXC_VECTOR(VEC), .REFILL_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .inst_valid_i(inst_valid_i),
        .pc_i(pc_i), .in_delayslot_i(in_delayslot_i), .mem_addr_i(mem_addr_i),
        .exc_flags_i(exc_flags_i), .int_i(int_i), .status_i(status_i),
        .cause_i(cause_i), .epc_i(epc_i), .cp0_we_i(cp0_we_i),
        .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
        .excepttype_o(et1), .exc_pc_o(epc1), .exc_ds_o(ds1),
        .bad_addr_o(bad1), .flush_o(flush1), .newpc_o(npc1), .busy_o(busy1)
    );

    typedef struct packed {
        logic [31:0] et;
        logic [31:0] npc;
        logic [31:0] pc;
        logic [31:0] bad;
        logic        ds;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic exp_t mk(input logic [31:0] et, input logic [31:0] npc,
                                input logic [31:0] pc, input logic [31:0] bad, input logic ds);
        exp_t e;
        e.et = et; e.npc = npc; e.pc = pc; e.bad = bad; e.ds = ds;
        return e;
    endfunction

    // scoreboard: every commit pops one expectation; otherwise the CP0 outputs must be zero
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (flush_o === 1'b1 || excepttype_o !== 32'd0) begin
                n_chk++;
                if (sbq.size() == 0) begin
                    $display("FAIL unexpected_commit got et=%h flush=%b npc=%h required no commit",
                             excepttype_o, flush_o, newpc_o);
                end else begin
                    mon_e = sbq.pop_front();
                    if ({flush_o, excepttype_o, newpc_o, exc_pc_o, bad_addr_o, exc_ds_o} !==
                        {1'b1, mon_e.et, mon_e.npc, mon_e.pc, mon_e.bad, mon_e.ds})
                        $display("FAIL commit got flush=%b et=%h npc=%h pc=%h bad=%h ds=%b required flush=1 et=%h npc=%h pc=%h bad=%h ds=%b",
                                 flush_o, excepttype_o, newpc_o, exc_pc_o, bad_addr_o, exc_ds_o,
                                 mon_e.et, mon_e.npc, mon_e.pc, mon_e.bad, mon_e.ds);
                    else
                        n_pass++;
                end
            end else begin
                n_chk++;
                if ({newpc_o, exc_pc_o, bad_addr_o, exc_ds_o} !== 97'd0)
                    $display("FAIL idle_outputs got npc=%h pc=%h bad=%h ds=%b required all 0",
                             newpc_o, exc_pc_o, bad_addr_o, exc_ds_o);
                else
                    n_pass++;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stall_i = 0; inst_valid_i = 0; in_delayslot_i = 0; cp0_we_i = 0;
        pc_i = 0; mem_addr_i = 0; status_i = 0; cause_i = 0; epc_i = 0;
        cp0_wdata_i = 0; exc_flags_i = 0; int_i = 0; cp0_waddr_i = 0;
    endtask

    // push expectation, hold inputs until it is consumed, then clear and wait out the refill
    task automatic run_commit(input exp_t e, output bit drained, output bit idled);
        sbq.push_back(e);
        drained = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (sbq.size() == 0) begin drained = 1; break; end
        end
        sbq.delete();
        next();
        clear_in();
        idled = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (busy_o === 1'b0) begin idled = 1; break; end
        end
        next();
    endtask

    task automatic test_reset();
        rst = 1; clear_in();
        next(); next();
        inst_valid_i = 1; exc_flags_i = 9'(1 << F_SYS); pc_i = 32'h80000010;
        @(negedge clk); #1;
        n_chk++; if (flush_o !== 1'b0) $display("FAIL reset_flush got %b required 0", flush_o); else n_pass++;
        n_chk++; if (excepttype_o !== 32'd0) $display("FAIL reset_et got %h required 0", excepttype_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b required 0", busy_o); else n_pass++;
        n_chk++; if (newpc_o !== 32'd0) $display("FAIL reset_newpc got %h required 0", newpc_o); else n_pass++;
        next();
        clear_in();
        rst = 0;
        next();
    endtask

    task automatic test_syscall();
        bit ok;
        pc_i = 32'h80001000; inst_valid_i = 1; exc_flags_i = 9'(1 << F_SYS);
        sbq.push_back(mk(32'h08, VEC, 32'h80001000, 32'd0, 1'b0));
        @(negedge clk); #1;
        ok = (sbq.size() == 0);
        n_chk++; if (!ok) $display("FAIL syscall_commit got pending=%0d required 0", sbq.size()); else n_pass++;
        sbq.delete();
        next();   // second syscall held during refill must be ignored
        @(negedge clk); #1;
        n_chk++; if (busy_o !== 1'b1) $display("FAIL syscall_busy1 got %b required 1", busy_o); else n_pass++;
        n_chk++; if (busy1 !== 1'b1) $display("FAIL refill1_busy1 got %b required 1", busy1); else n_pass++;
        next();
        @(negedge clk); #1;
        n_chk++; if (busy_o !== 1'b1) $display("FAIL syscall_busy2 got %b required 1", busy_o); else n_pass++;
        n_chk++; if (busy1 !== 1'b0) $display("FAIL refill1_busy2 got %b required 0", busy1); else n_pass++;
        next();
        clear_in();
        @(negedge clk); #1;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL syscall_busy3 got %b required 0", busy_o); else n_pass++;
        next(); next(); next();
    endtask

    task automatic test_eret();
        bit d, i;
        pc_i = 32'h80000200; inst_valid_i = 1; exc_flags_i = 9'(1 << F_ERET);
        epc_i = 32'h80000040; cp0_we_i = 1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'h80000100;
        run_commit(mk(32'h0e, 32'h80000100, 32'h80000200, 32'd0, 1'b0), d, i);
        n_chk++; if (!(d && i)) $display("FAIL eret_fwd got drained=%b idle=%b required 1 1", d, i); else n_pass++;
        pc_i = 32'h80000204; inst_valid_i = 1; exc_flags_i = 9'(1 << F_ERET); epc_i = 32'h80000040;
        run_commit(mk(32'h0e, 32'h80000040, 32'h80000204, 32'd0, 1'b0), d, i);
        n_chk++; if (!(d && i)) $display("FAIL eret_plain got drained=%b idle=%b required 1 1", d, i); else n_pass++;
    endtask

    task automatic test_interrupt();
        bit d, i;
        pc_i = 32'h80003000; in_delayslot_i = 1; inst_valid_i = 1; int_i = 6'h01; status_i = 32'h0000FC01;
        run_commit(mk(32'h01, VEC, 32'h80003000, 32'd0, 1'b1), d, i);
        n_chk++; if (!(d && i)) $display("FAIL int_hw got drained=%b idle=%b required 1 1", d, i); else n_pass++;
        // EXL set: never taken
        pc_i = 32'h80003004; inst_valid_i = 1; int_i = 6'h01; status_i = 32'h0000FC03;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            n_chk++; if (flush_o !== 1'b0) $display("FAIL int_exl got flush=%b required 0", flush_o); else n_pass++;
            next();
        end
        // same-cycle MTC0 Status clearing IE beats the pending interrupt
        status_i = 32'h0000FC01; cp0_we_i = 1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h0000FC00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            n_chk++; if (flush_o !== 1'b0) $display("FAIL int_ie_fwd got flush=%b required 0", flush_o); else n_pass++;
            next();
        end
        clear_in();
        next(); next(); next();
        // software interrupt via forwarded Cause IP0
        pc_i = 32'h80003008; inst_valid_i = 1; status_i = 32'h00000101;
        cp0_we_i = 1; cp0_waddr_i = 5'd13; cp0_wdata_i = 32'h00000100;
        run_commit(mk(32'h01, VEC, 32'h80003008, 32'd0, 1'b0), d, i);
        n_chk++; if (!(d && i)) $display("FAIL int_sw_fwd got drained=%b idle=%b required 1 1", d, i); else n_pass++;
    endtask

    task automatic test_priority();
        bit d, i;
        logic [8:0]  fl [8];
        logic [31:0] cd [8];
        logic [1:0]  bs [8];   // 0: none, 1: pc, 2: mem_addr
        logic [31:0] pc, bad;
        fl[0] = 9'(1 << F_ADELD) | 9'(1 << F_OV);                    cd[0] = 32'h0c; bs[0] = 0;
        fl[1] = 9'(1 << F_ADELD);                                    cd[1] = 32'h04; bs[1] = 2;
        fl[2] = 9'(1 << F_ADELF) | 9'(1 << F_RI) | 9'(1 << F_ADES);  cd[2] = 32'h04; bs[2] = 1;
        fl[3] = 9'(1 << F_RI) | 9'(1 << F_SYS) | 9'(1 << F_BRK);     cd[3] = 32'h0a; bs[3] = 0;
        fl[4] = 9'(1 << F_SYS) | 9'(1 << F_BRK) | 9'(1 << F_ERET);   cd[4] = 32'h08; bs[4] = 0;
        fl[5] = 9'(1 << F_BRK) | 9'(1 << F_OV);                      cd[5] = 32'h09; bs[5] = 0;
        fl[6] = 9'(1 << F_TRAP) | 9'(1 << F_ADELD);                  cd[6] = 32'h0d; bs[6] = 0;
        fl[7] = 9'(1 << F_ADES) | 9'(1 << F_ERET);                   cd[7] = 32'h05; bs[7] = 2;
        for (int k = 0; k < 8; k++) begin
            pc  = 32'h80004000 + 32'(k * 4);
            bad = (bs[k] == 2'd1) ? pc : (bs[k] == 2'd2) ? 32'h80002001 : 32'd0;
            pc_i = pc; mem_addr_i = 32'h80002001; in_delayslot_i = k[0];
            inst_valid_i = 1; exc_flags_i = fl[k];
            run_commit(mk(cd[k], VEC, pc, bad, k[0]), d, i);
            n_chk++; if (!(d && i)) $display("FAIL prio_%0d got drained=%b idle=%b required 1 1", k, d, i); else n_pass++;
        end
        // bubble carrying flags commits nothing
        pc_i = 32'h80004100; inst_valid_i = 0; exc_flags_i = 9'(1 << F_SYS);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_chk++; if (flush_o !== 1'b0) $display("FAIL bubble got flush=%b required 0", flush_o); else n_pass++;
            next();
        end
        clear_in();
        next();
    endtask

    task automatic test_stall();
        bit d, i;
        pc_i = 32'h80006000; inst_valid_i = 1; exc_flags_i = 9'(1 << F_RI); stall_i = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_chk++; if ({flush_o, excepttype_o} !== 33'd0)
                $display("FAIL stall_%0d got flush=%b et=%h required 0 0", k, flush_o, excepttype_o);
            else n_pass++;
            next();
        end
        stall_i = 0;
        run_commit(mk(32'h0a, VEC, 32'h80006000, 32'd0, 1'b0), d, i);
        n_chk++; if (!(d && i)) $display("FAIL stall_release got drained=%b idle=%b required 1 1", d, i); else n_pass++;
    endtask

    task automatic test_reset_refill();
        bit d, i;
        pc_i = 32'h80005000; inst_valid_i = 1; exc_flags_i = 9'(1 << F_SYS);
        sbq.push_back(mk(32'h08, VEC, 32'h80005000, 32'd0, 1'b0));
        @(negedge clk); #1;
        n_chk++; if (sbq.size() != 0) $display("FAIL rr_first got pending=%0d required 0", sbq.size()); else n_pass++;
        sbq.delete();
        next();
        rst = 1;
        @(negedge clk); #1;
        n_chk++; if ({busy_o, flush_o, excepttype_o} !== 34'd0)
            $display("FAIL rr_in_reset got busy=%b flush=%b et=%h required 0 0 0", busy_o, flush_o, excepttype_o);
        else n_pass++;
        next();
        rst = 0;
        run_commit(mk(32'h08, VEC, 32'h80005000, 32'd0, 1'b0), d, i);
        n_chk++; if (!(d && i)) $display("FAIL rr_fresh got drained=%b idle=%b required 1 1", d, i); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_syscall();
        test_eret();
        test_interrupt();
        test_priority();
        test_stall();
        test_reset_refill();
        next(); next();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
